mem_system: RTL and testbench

// - Accumulator-style datapath with attached memory: 8-entry register bank, ALU, post-ALU shifter, flags, IR, MAR, MDR, RAM.
// - Sits under the control unit, which drives every control input each cycle.
// - Exposes monitor buses and the decoded opcode field back to the controller.

---
 rtl/mem_system.sv | 119 +++++++++++
 tb/tb_mem_system.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_system.sv
// Accumulator datapath: 8-entry register bank, ALU, post-ALU shifter, flags,
// IR/MAR/MDR and an asynchronously read RAM. Every control input is driven each cycle.
module mem_system #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ir_sclr,
  input  logic                  mar_sclr,
  input  logic                  enaf,
  input  logic [2:0]            selop,
  input  logic [1:0]            shamt,
  input  logic                  bank_wr_en,
  input  logic [2:0]            busB_addr,
  input  logic [2:0]            busC_addr,
  input  logic                  ir_en,
  input  logic                  mar_en,
  input  logic                  wr_rdn,
  input  logic                  mdr_alu_n,
  input  logic                  mdr_en,
  output logic [DATA_WIDTH-1:0] busC_m,
  output logic [DATA_WIDTH-1:0] bus_alu_m,
  output logic [DATA_WIDTH-1:0] PC_m,
  output logic [DATA_WIDTH-1:0] DPTR_m,
  output logic [DATA_WIDTH-1:0] A_m,
  output logic [DATA_WIDTH-1:0] TEMP_m,
  output logic [DATA_WIDTH-1:0] ACC_m,
  output logic [4:0]            instruction,
  output logic                  C,
  output logic                  N,
  output logic                  P,
  output logic                  Z
);
  localparam int DW = DATA_WIDTH;

  logic [DW-1:0] bank [8];
  logic [DW-1:0] ir, mar, mdr;
  logic [DW-1:0] mem [2**DW];

  logic [DW-1:0] bus_b, alu_x, alu_r, sh_out, bus_c, mem_dout;
  logic          alu_c, sh_c;

  assign bus_b    = bank[busB_addr];
  assign alu_x    = bank[2];
  assign mem_dout = mem[mar];

  // Subtraction in DW+1 bits leaves the borrow in the top bit.
  always_comb begin
    alu_r = '0;
    alu_c = 1'b0;
    case (selop)
      3'b000: alu_r = bus_b;
      3'b001: {alu_c, alu_r} = {1'b0, alu_x} + {1'b0, bus_b};
      3'b010: {alu_c, alu_r} = {1'b0, alu_x} - {1'b0, bus_b};
      3'b011: alu_r = alu_x & bus_b;
      3'b100: alu_r = alu_x | bus_b;
      3'b101: alu_r = alu_x ^ bus_b;
      3'b110: alu_r = ~bus_b;
      3'b111: {alu_c, alu_r} = {1'b0, bus_b} + {{DW{1'b0}}, 1'b1};
      default: alu_r = '0;
    endcase
  end

  always_comb begin
    sh_out = alu_r;
    sh_c   = alu_c;
    case (shamt)
      2'b01: {sh_c, sh_out} = {alu_r, 1'b0};
      2'b10: {sh_out, sh_c} = {1'b0, alu_r};
      2'b11: begin
        sh_out = {alu_r[DW-2:0], alu_r[DW-1]};
        sh_c   = alu_r[DW-1];
      end
      default: ;
    endcase
  end

  assign bus_c = mdr_alu_n ? mdr : sh_out;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 8; i++) bank[i] <= '0;
      ir  <= '0;
      mar <= '0;
      mdr <= '0;
      C   <= 1'b0;
      N   <= 1'b0;
      P   <= 1'b0;
      Z   <= 1'b0;
    end else begin
      if (bank_wr_en) bank[busC_addr] <= bus_c;
      if (ir_sclr)      ir <= '0;
      else if (ir_en)   ir <= mem_dout;
      if (mar_sclr)     mar <= '0;
      else if (mar_en)  mar <= bus_c;
      if (mdr_en)       mdr <= wr_rdn ? bus_c : mem_dout;
      if (enaf) begin
        C <= sh_c;
        N <= sh_out[DW-1];
        P <= ~^sh_out;
        Z <= (sh_out == '0);
      end
    end
  end

  // RAM keeps its contents through reset; writes use the MDR value from before the edge.
  always_ff @(posedge clk) begin
    if (wr_rdn) mem[mar] <= mdr;
  end

  assign busC_m      = bus_c;
  assign bus_alu_m   = sh_out;
  assign PC_m        = bank[0];
  assign DPTR_m      = bank[1];
  assign A_m         = bank[2];
  assign TEMP_m      = bank[3];
  assign ACC_m       = bank[7];
  assign instruction = ir[DW-1:DW-5];
endmodule

// File: tb/tb_mem_system.sv
// Directed bench for mem_system: a reference model of bank and flags feeds an
// expected queue that is checked after each clock edge, plus fixed-value checks.
module tb_mem_system;
  logic       clk = 1'b0;
  logic       rst;
  logic       ir_sclr, mar_sclr, enaf, bank_wr_en, ir_en, mar_en, wr_rdn, mdr_alu_n, mdr_en;
  logic [2:0] selop, busB_addr, busC_addr;
  logic [1:0] shamt;
  logic [7:0] busC_m, bus_alu_m, PC_m, DPTR_m, A_m, TEMP_m, ACC_m;
  logic [4:0] instruction;
  logic       C, N, P, Z;

  int checks = 0;
  int errors = 0;

  // {visible, register value, C, N, P, Z}
  logic [12:0] exp_q[$];
  logic [7:0]  mbank [8];
  logic        mc, mn, mp, mz;

  mem_system #(.DATA_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .ir_sclr(ir_sclr), .mar_sclr(mar_sclr), .enaf(enaf),
    .selop(selop), .shamt(shamt), .bank_wr_en(bank_wr_en), .busB_addr(busB_addr),
    .busC_addr(busC_addr), .ir_en(ir_en), .mar_en(mar_en), .wr_rdn(wr_rdn),
    .mdr_alu_n(mdr_alu_n), .mdr_en(mdr_en), .busC_m(busC_m), .bus_alu_m(bus_alu_m),
    .PC_m(PC_m), .DPTR_m(DPTR_m), .A_m(A_m), .TEMP_m(TEMP_m), .ACC_m(ACC_m),
    .instruction(instruction), .C(C), .N(N), .P(P), .Z(Z)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] mon(input logic [2:0] a);
    case (a)
      3'd0:    return PC_m;
      3'd1:    return DPTR_m;
      3'd2:    return A_m;
      3'd3:    return TEMP_m;
      3'd7:    return ACC_m;
      default: return 8'h00;
    endcase
  endfunction

  task automatic idle_ctrl();
    ir_sclr = 0; mar_sclr = 0; enaf = 0; bank_wr_en = 0; ir_en = 0; mar_en = 0;
    wr_rdn = 0; mdr_alu_n = 0; mdr_en = 0; selop = 0; shamt = 0; busB_addr = 0; busC_addr = 0;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) mbank[i] = 8'h00;
    {mc, mn, mp, mz} = 4'b0000;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // One ALU/shifter cycle: predict, check the combinational result, then check after the edge.
  task automatic op(input logic [2:0] sel, input logic [1:0] sh, input logic [2:0] bb,
                    input logic [2:0] bc, input logic wr, input logic en);
    logic [7:0] x, y, r, s;
    logic [8:0] t;
    logic       c, sc, vis;
    logic [12:0] e;
    idle_ctrl();
    selop = sel; shamt = sh; busB_addr = bb; busC_addr = bc; bank_wr_en = wr; enaf = en;
    x = mbank[2];
    y = mbank[bb];
    c = 1'b0;
    r = 8'h00;
    case (sel)
      3'd0: r = y;
      3'd1: begin t = 9'(x) + 9'(y); r = t[7:0]; c = t[8]; end
      3'd2: begin r = x - y; c = (x < y); end
      3'd3: r = x & y;
      3'd4: r = x | y;
      3'd5: r = x ^ y;
      3'd6: r = ~y;
      default: begin t = 9'(y) + 9'd1; r = t[7:0]; c = t[8]; end
    endcase
    case (sh)
      2'd0: begin s = r; sc = c; end
      2'd1: begin s = r << 1; sc = r[7]; end
      2'd2: begin s = r >> 1; sc = r[0]; end
      default: begin s = {r[6:0], r[7]}; sc = r[7]; end
    endcase
    #1;
    check("alu_out", {8'h00, bus_alu_m}, {8'h00, s});
    if (wr) mbank[bc] = s;
    if (en) begin
      mc = sc; mn = s[7]; mz = (s == 8'h00); mp = ($countones(s) % 2 == 0);
    end
    vis = (bc inside {3'd0, 3'd1, 3'd2, 3'd3, 3'd7});
    exp_q.push_back({vis, mbank[bc], mc, mn, mp, mz});
    cyc();
    e = exp_q.pop_front();
    if (e[12]) check("dest_reg", {8'h00, mon(bc)}, {8'h00, e[11:4]});
    check("flags_cnpz", {12'h000, C, N, P, Z}, {12'h000, e[3:0]});
  endtask

  // Eight shift-then-maybe-increment steps build any value regardless of the start value.
  task automatic load_reg(input logic [2:0] a, input logic [7:0] v);
    for (int i = 7; i >= 0; i--) begin
      op(3'd0, 2'd1, a, a, 1'b1, 1'b0);
      if (v[i]) op(3'd7, 2'd0, a, a, 1'b1, 1'b0);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_pc"},   {8'h00, PC_m},   16'h0);
    check({tag, "_dptr"}, {8'h00, DPTR_m}, 16'h0);
    check({tag, "_a"},    {8'h00, A_m},    16'h0);
    check({tag, "_temp"}, {8'h00, TEMP_m}, 16'h0);
    check({tag, "_acc"},  {8'h00, ACC_m},  16'h0);
    check({tag, "_busc"}, {8'h00, busC_m}, 16'h0);
    check({tag, "_alu"},  {8'h00, bus_alu_m}, 16'h0);
    check({tag, "_instr"}, {11'h000, instruction}, 16'h0);
    check({tag, "_flags"}, {12'h000, C, N, P, Z}, 16'h0);
  endtask

  initial begin
    idle_ctrl();
    model_reset();
    rst = 1'b0;
    #12;
    check_all_zero("reset");
    @(negedge clk);
    rst = 1'b1;

    // Shift of zero: ACC stays 0, Z and P set
    op(3'd0, 2'd1, 3'd7, 3'd7, 1'b1, 1'b1);
    check("zero_acc", {8'h00, ACC_m}, 16'h0000);
    check("zero_zp", {14'h0, Z, P}, 16'h0003);

    // Increment three times, then shift left
    repeat (3) op(3'd7, 2'd0, 3'd7, 3'd7, 1'b1, 1'b1);
    check("inc_acc", {8'h00, ACC_m}, 16'h0003);
    op(3'd0, 2'd1, 3'd7, 3'd7, 1'b1, 1'b1);
    check("shl_acc", {8'h00, ACC_m}, 16'h0006);
    check("shl_cnzp", {12'h000, C, N, Z, P}, 16'h0001);

    // Shifter carry-out on each mode
    load_reg(3'd7, 8'h80);
    op(3'd0, 2'd1, 3'd7, 3'd7, 1'b1, 1'b1);
    check("shout_acc", {8'h00, ACC_m}, 16'h0000);
    check("shout_cz", {14'h0, C, Z}, 16'h0003);
    load_reg(3'd7, 8'h80);
    op(3'd0, 2'd3, 3'd7, 3'd7, 1'b1, 1'b1);
    check("rol_acc", {8'h00, ACC_m}, 16'h0001);
    check("rol_c", {15'h0, C}, 16'h0001);
    load_reg(3'd7, 8'h81);
    op(3'd0, 2'd2, 3'd7, 3'd7, 1'b1, 1'b1);
    check("shr_acc", {8'h00, ACC_m}, 16'h0040);
    check("shr_c", {15'h0, C}, 16'h0001);

    // Every ALU op against A=0x5A, TEMP=0x3C into ACC
    load_reg(3'd2, 8'h5A);
    load_reg(3'd3, 8'h3C);
    for (int s = 1; s < 7; s++) op(3'(s), 2'd0, 3'd3, 3'd7, 1'b1, 1'b1);
    load_reg(3'd2, 8'hFF);
    load_reg(3'd3, 8'h01);
    op(3'd1, 2'd0, 3'd3, 3'd7, 1'b1, 1'b1);
    check("add_wrap_c", {15'h0, C}, 16'h0001);
    load_reg(3'd7, 8'hFF);
    op(3'd7, 2'd0, 3'd7, 3'd7, 1'b1, 1'b1);
    check("inc_wrap_acc", {8'h00, ACC_m}, 16'h0000);

    // Subtraction with and without borrow
    load_reg(3'd2, 8'h07);
    load_reg(3'd7, 8'h05);
    op(3'd2, 2'd0, 3'd7, 3'd7, 1'b1, 1'b1);
    check("sub_acc", {8'h00, ACC_m}, 16'h0002);
    check("sub_c", {15'h0, C}, 16'h0000);
    load_reg(3'd2, 8'h02);
    load_reg(3'd7, 8'h03);
    op(3'd2, 2'd0, 3'd7, 3'd7, 1'b1, 1'b1);
    check("borrow_acc", {8'h00, ACC_m}, 16'h00FF);
    check("borrow_cnp", {13'h0, C, N, P}, 16'h0007);

    // Memory: mem[0] <= 0x3C (MAR is 0 since reset)
    load_reg(3'd4, 8'h3C);
    idle_ctrl(); busB_addr = 3'd4; mdr_en = 1; wr_rdn = 1;
    cyc();
    idle_ctrl(); wr_rdn = 1; mdr_alu_n = 1;
    #1;
    check("mdr_from_busc", {8'h00, busC_m}, 16'h003C);
    cyc();

    // MAR <= 0x10, MDR <= 0xA8, write, read back into IR and MDR
    load_reg(3'd4, 8'h10);
    idle_ctrl(); busB_addr = 3'd4; mar_en = 1;
    cyc();
    load_reg(3'd4, 8'hA8);
    idle_ctrl(); busB_addr = 3'd4; mdr_en = 1; wr_rdn = 1;
    cyc();
    idle_ctrl(); wr_rdn = 1;
    cyc();
    load_reg(3'd4, 8'h00);
    idle_ctrl(); busB_addr = 3'd4; mdr_en = 1; wr_rdn = 1;
    cyc();
    idle_ctrl(); ir_en = 1; mdr_en = 1; mdr_alu_n = 1;
    cyc();
    check("ir_read", {11'h000, instruction}, 16'h0015);
    check("mdr_read", {8'h00, busC_m}, 16'h00A8);

    // Clear priority: MAR cleared despite mar_en, IR cleared despite ir_en
    idle_ctrl(); busB_addr = 3'd4; mar_sclr = 1; mar_en = 1;
    load_reg(3'd4, 8'h10);
    idle_ctrl(); busB_addr = 3'd4; mar_sclr = 1; mar_en = 1;
    cyc();
    idle_ctrl(); ir_en = 1;
    cyc();
    check("mar_sclr", {11'h000, instruction}, 16'h0007);
    idle_ctrl(); ir_en = 1; ir_sclr = 1;
    cyc();
    check("ir_sclr", {11'h000, instruction}, 16'h0000);

    // Reset in the middle of a cycle clears registers at once; RAM survives
    idle_ctrl(); ir_en = 1;
    cyc();
    load_reg(3'd7, 8'h5D);
    load_reg(3'd0, 8'h21);
    op(3'd6, 2'd0, 3'd0, 3'd1, 1'b1, 1'b1);
    idle_ctrl(); mdr_alu_n = 1;
    #2;
    rst = 1'b0;
    model_reset();
    #1;
    check_all_zero("midreset");
    @(negedge clk);
    rst = 1'b1;
    load_reg(3'd4, 8'h10);
    idle_ctrl(); busB_addr = 3'd4; mar_en = 1;
    cyc();
    idle_ctrl(); ir_en = 1;
    cyc();
    check("ram_kept", {11'h000, instruction}, 16'h0015);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
